// File: rtl/cdc_hs_tx.sv
// Source side of a two-phase toggle req/ack handshake. It holds one word stable on
// xfer_data and waits for the synchronized ack toggle before it accepts the next word.
module cdc_hs_tx #(
  parameter int DATA_W  = 8,
  parameter int NUM_FFS = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] xfer_data,
  output logic              xfer_req,
  input  logic              xfer_ack,
  output logic              busy,
  output logic              done_pulse,
  output logic [CNT_W-1:0]  last_rtt,
  output logic              proto_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [NUM_FFS-1:0]  ack_ff_q, ack_ff_d;
  logic                req_q, req_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    rtt_q, rtt_d;
  logic                err_q, err_d;
  logic                ack_sync;
  logic                ack_match;

  // Only the last synchronizer stage feeds logic; raw xfer_ack is never decoded.
  assign ack_sync  = ack_ff_q[NUM_FFS-1];
  assign ack_match = (ack_sync == req_q);

  always_comb begin
    ack_ff_d = {ack_ff_q[NUM_FFS-2:0], xfer_ack};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_ff_q <= '0;
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      rtt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ack_ff_q <= ack_ff_d;
      state_q  <= state_d;
      req_q    <= req_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      rtt_q    <= rtt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    rtt_d    = rtt_q;
    err_d    = err_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = ack_match;
        // An ack toggle with nothing outstanding means the far side misbehaved.
        if (!ack_match) err_d = 1'b1;
        if (in_valid && ack_match) begin
          data_d  = in_data;
          req_d   = ~req_q;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (ack_match) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rtt_d   = cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign xfer_data  = data_q;
  assign xfer_req   = req_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign last_rtt   = rtt_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx: a destination-side monitor checks xfer_data against a
// scoreboard queue on every xfer_req toggle. A CNT_W=4 twin checks rtt saturation.
module tb_cdc_hs_tx;
  localparam int DATA_W = 8;
  localparam int NFF    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              xfer_ack;
  logic              in_ready, xfer_req, busy, done_pulse, proto_err;
  logic [DATA_W-1:0] xfer_data;
  logic [7:0]        last_rtt;
  logic              in_ready4, xfer_req4, busy4, done_pulse4, proto_err4;
  logic [DATA_W-1:0] xfer_data4;
  logic [3:0]        last_rtt4;

  int ntests = 0;
  int nfail  = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic seen_req = 1'b0;

  cdc_hs_tx #(.DATA_W(DATA_W), .NUM_FFS(NFF), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .xfer_data(xfer_data), .xfer_req(xfer_req),
    .xfer_ack(xfer_ack), .busy(busy), .done_pulse(done_pulse),
    .last_rtt(last_rtt), .proto_err(proto_err));

  cdc_hs_tx #(.DATA_W(DATA_W), .NUM_FFS(NFF), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .xfer_data(xfer_data4), .xfer_req(xfer_req4),
    .xfer_ack(xfer_ack), .busy(busy4), .done_pulse(done_pulse4),
    .last_rtt(last_rtt4), .proto_err(proto_err4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Destination model: samples xfer_data when it sees xfer_req change.
  always @(negedge clk) begin
    if (!rst_n) seen_req = 1'b0;
    else if (xfer_req !== seen_req) begin
      seen_req = xfer_req;
      if (sb_q.size() == 0) chk("sb_unexpected_req", {31'd0, xfer_req}, 32'hFFFF_FFFF);
      else chk("sb_data", xfer_data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int k_at;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; xfer_ack = 1'b0;

    // Reset
    #22;
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_rtt", last_rtt, 0);
    chk("rst_err", proto_err, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_ready", in_ready, 1);

    // Single transfer, ack toggled 5 cycles after accept
    in_data = 8'hA5; in_valid = 1'b1; sb_q.push_back(8'hA5);
    tick(); in_valid = 1'b0; in_data = 8'h00;
    chk("st_req", xfer_req, 1);
    chk("st_data", xfer_data, 8'hA5);
    chk("st_busy", busy, 1);
    chk("st_ready", in_ready, 0);
    repeat (4) tick();
    xfer_ack = 1'b1;
    tick(); chk("st_nodone1", done_pulse, 0);
    tick(); chk("st_nodone2", done_pulse, 0);
    tick();
    chk("st_done", done_pulse, 1);
    chk("st_busy_clr", busy, 0);
    chk("st_rtt", last_rtt, 6);
    chk("st_rtt4", last_rtt4, 6);
    tick(); chk("st_done_1cyc", done_pulse, 0);

    // Back-to-back with in_valid held high, from a fresh reset
    @(negedge clk); rst_n = 1'b0; xfer_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    in_valid = 1'b1; in_data = 8'h01; sb_q.push_back(8'h01);
    chk("b2b_rdy0", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      logic [DATA_W-1:0] w;
      w = DATA_W'(i + 1);
      tick();
      in_data = 8'hFF;
      chk("b2b_req", xfer_req, (i % 2 == 0) ? 1 : 0);
      chk("b2b_data", xfer_data, w);
      chk("b2b_busy", busy, 1);
      chk("b2b_ready", in_ready, 0);
      repeat (2) begin tick(); chk("b2b_hold", xfer_data, w); end
      xfer_ack = ~xfer_ack;
      got = 0; k_at = -1;
      for (int k = 0; k < 10 && got == 0; k++) begin
        tick();
        if (done_pulse) begin got = 1; k_at = k; end
        else chk("b2b_hold_w", xfer_data, w);
      end
      chk("b2b_done", got, 1);
      chk("b2b_done_lat", k_at, NFF);
      chk("b2b_rdy_done", in_ready, 1);
      if (i < 2) begin
        in_data = DATA_W'(i + 2); sb_q.push_back(DATA_W'(i + 2));
      end else in_valid = 1'b0;
    end

    // Spurious ack while IDLE (req=1, ack=1 now)
    tick();
    xfer_ack = 1'b0;
    tick(); chk("sp_err1", proto_err, 0); chk("sp_rdy1", in_ready, 1);
    tick(); chk("sp_err2", proto_err, 0); chk("sp_rdy2", in_ready, 0);
    tick(); chk("sp_err3", proto_err, 1);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (4) tick();
    chk("sp_noxfer_req", xfer_req, 1);
    chk("sp_noxfer_busy", busy, 0);
    chk("sp_rdy_blk", in_ready, 0);
    in_valid = 1'b0;
    xfer_ack = 1'b1;
    tick(); chk("sp_rdy_e1", in_ready, 0);
    tick(); chk("sp_rdy_back", in_ready, 1);
    tick(); chk("sp_err_sticky", proto_err, 1);

    // Reset in the middle of WAIT (accept toggles req 1->0)
    in_valid = 1'b1; in_data = 8'h5A; sb_q.push_back(8'h5A);
    tick(); in_valid = 1'b0;
    chk("rm_busy", busy, 1);
    chk("rm_data", xfer_data, 8'h5A);
    tick();
    rst_n = 1'b0; xfer_ack = 1'b0;
    #1;
    chk("rm_busy0", busy, 0);
    chk("rm_req0", xfer_req, 0);
    chk("rm_data0", xfer_data, 0);
    chk("rm_err0", proto_err, 0);
    @(negedge clk); rst_n = 1'b1;
    got = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (done_pulse || busy) got = 1; end
    chk("rm_no_done", got, 0);
    chk("rm_no_err", proto_err, 0);

    // RTT saturation: ack toggled 40 cycles after accept
    in_valid = 1'b1; in_data = 8'h3C; sb_q.push_back(8'h3C);
    tick(); in_valid = 1'b0;
    repeat (39) tick();
    xfer_ack = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin tick(); if (done_pulse) got = 1; end
    chk("sat_done", got, 1);
    chk("sat_done4", done_pulse4, 1);
    chk("sat_rtt8", last_rtt, 41);
    chk("sat_rtt4", last_rtt4, 15);
    chk("sat_busy", busy4, 0);

    tick(); tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
